// File: rtl/hazard_unit_pkg.sv
// Shared encodings and the scoreboard entry layout for the pipeline interlock unit.
package hazard_unit_pkg;

   localparam int SB_REG_W = 5;

   localparam logic [2:0] INST_NORMAL = 3'd0;
   localparam logic [2:0] INST_JR     = 3'd1;
   localparam logic [2:0] INST_LW     = 3'd2;
   localparam logic [2:0] INST_J_TYPE = 3'd3;
   localparam logic [2:0] INST_BEQ    = 3'd4;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                v;
      logic                rw;
      logic [SB_REG_W-1:0] wnum;
      logic                is_lw;
      logic                is_beq;
      logic [SB_REG_W-1:0] rs;
      logic [SB_REG_W-1:0] rt;
      logic                use_rs;
      logic                use_rt;
   } sb_entry_t;

   localparam int SB_W = $bits(sb_entry_t);

   // A producer only counts when it really writes a non-zero register.
   function automatic logic sb_hit(sb_entry_t e, logic [SB_REG_W-1:0] r);
      return e.v && e.rw && (e.wnum != {SB_REG_W{1'b0}}) && (e.wnum == r);
   endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One shadow scoreboard entry: loads the older stage's entry, or a bubble.
module hazard_sb_stage
   import hazard_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            advance,
   input  logic            bubble,
   input  logic [SB_W-1:0] d,
   output logic [SB_W-1:0] q
);

   logic [SB_W-1:0] q_r;

   // Entry register; a bubble clears the valid bit along with everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r <= {SB_W{1'b0}};
      end else if (advance) begin
         q_r <= bubble ? {SB_W{1'b0}} : d;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the 5-stage core, driven by a private
// EX/MEM/WB scoreboard built from the ID-stage control bundle.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_W = SB_REG_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [2:0]       id_inst_type,
   input  logic             id_reg_write,
   input  logic [REG_W-1:0] id_wnum,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             mem_zero,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             beq_redirect,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_jr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   sb_entry_t       id_ent_s, ex_s, mem_s, wb_s;
   logic [SB_W-1:0] ex_vec_s, mem_vec_s, wb_vec_s;
   logic            beq_take_s, load_use_s, jr_wait_s, stall_s;
   logic            id_is_jr_s, id_is_j_s, j_flush_s, jr_flush_s, flush_ev_s;
   logic [1:0]      fwd_a_s, fwd_b_s, fwd_jr_s;
   logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
   logic            sb_unused_s;

   // Pack the ID-stage control bundle into a scoreboard entry.
   always_comb begin
      id_ent_s        = {SB_W{1'b0}};
      id_ent_s.v      = id_valid;
      id_ent_s.rw     = id_reg_write;
      id_ent_s.wnum   = id_wnum;
      id_ent_s.is_lw  = (id_inst_type == INST_LW);
      id_ent_s.is_beq = (id_inst_type == INST_BEQ);
      id_ent_s.rs     = id_rs;
      id_ent_s.rt     = id_rt;
      id_ent_s.use_rs = id_use_rs;
      id_ent_s.use_rt = id_use_rt;
   end

   hazard_sb_stage u_sb_ex (
      .clk(clk), .rst(rst), .advance(1'b1), .bubble(stall_s || beq_take_s),
      .d(id_ent_s), .q(ex_vec_s)
   );
   hazard_sb_stage u_sb_mem (
      .clk(clk), .rst(rst), .advance(1'b1), .bubble(beq_take_s),
      .d(ex_vec_s), .q(mem_vec_s)
   );
   hazard_sb_stage u_sb_wb (
      .clk(clk), .rst(rst), .advance(1'b1), .bubble(1'b0),
      .d(mem_vec_s), .q(wb_vec_s)
   );

   assign ex_s  = sb_entry_t'(ex_vec_s);
   assign mem_s = sb_entry_t'(mem_vec_s);
   assign wb_s  = sb_entry_t'(wb_vec_s);

   // Interlock decisions; a taken BEQ in MEM overrides anything younger.
   always_comb begin
      id_is_jr_s = (id_inst_type == INST_JR);
      id_is_j_s  = (id_inst_type == INST_J_TYPE);
      beq_take_s = mem_s.v && mem_s.is_beq && mem_zero;
      load_use_s = ex_s.is_lw &&
                   ((id_use_rs && sb_hit(ex_s, id_rs)) || (id_use_rt && sb_hit(ex_s, id_rt)));
      jr_wait_s  = id_is_jr_s &&
                   (sb_hit(ex_s, id_rs) || (sb_hit(mem_s, id_rs) && mem_s.is_lw));
      stall_s    = id_valid && (load_use_s || jr_wait_s) && !beq_take_s;
      j_flush_s  = id_valid && id_is_j_s && !beq_take_s;
      jr_flush_s = id_valid && id_is_jr_s && !stall_s && !beq_take_s;
      flush_ev_s = beq_take_s || j_flush_s || jr_flush_s;
   end

   // Operand forwarding into EX and the JR target bypass into ID.
   always_comb begin
      fwd_a_s  = FWD_REG;
      fwd_b_s  = FWD_REG;
      fwd_jr_s = FWD_REG;
      if (!ex_s.v) begin
         fwd_a_s = FWD_REG;
         fwd_b_s = FWD_REG;
      end else begin
         if (sb_hit(mem_s, ex_s.rs))     fwd_a_s = FWD_MEM;
         else if (sb_hit(wb_s, ex_s.rs)) fwd_a_s = FWD_WB;
         else                            fwd_a_s = FWD_REG;
         if (sb_hit(mem_s, ex_s.rt))     fwd_b_s = FWD_MEM;
         else if (sb_hit(wb_s, ex_s.rt)) fwd_b_s = FWD_WB;
         else                            fwd_b_s = FWD_REG;
      end
      // A load in MEM has no data yet, so it can only feed JR from WB.
      if (sb_hit(mem_s, id_rs) && !mem_s.is_lw) fwd_jr_s = FWD_MEM;
      else if (sb_hit(wb_s, id_rs))             fwd_jr_s = FWD_WB;
      else                                      fwd_jr_s = FWD_REG;
   end

   // Performance counters, wrapping naturally at full width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_s) stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         else         stall_cnt_r <= stall_cnt_r;
         if (flush_ev_s) flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         else            flush_cnt_r <= flush_cnt_r;
      end
   end

   assign pc_en        = !stall_s;
   assign ifid_en      = !stall_s;
   assign ifid_flush   = flush_ev_s;
   assign idex_flush   = stall_s || beq_take_s;
   assign exmem_flush  = beq_take_s;
   assign beq_redirect = beq_take_s;
   assign fwd_a        = fwd_a_s;
   assign fwd_b        = fwd_b_s;
   assign fwd_jr       = fwd_jr_s;
   assign stall_cnt    = stall_cnt_r;
   assign flush_cnt    = flush_cnt_r;

   assign sb_unused_s = ^{ex_s.is_beq, ex_s.use_rs, ex_s.use_rt,
                          mem_s.rs, mem_s.rt, mem_s.use_rs, mem_s.use_rt,
                          wb_s.is_lw, wb_s.is_beq, wb_s.rs, wb_s.rt, wb_s.use_rs, wb_s.use_rt};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus random control bundles,
// checked every cycle against an instruction-level pipeline model.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_reg_write, id_use_rs, id_use_rt, mem_zero;
   logic [2:0]  id_inst_type;
   logic [4:0]  id_wnum, id_rs, id_rt;
   logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, beq_redirect;
   logic [1:0]  fwd_a, fwd_b, fwd_jr;
   logic [31:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst_type(id_inst_type),
      .id_reg_write(id_reg_write), .id_wnum(id_wnum), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .mem_zero(mem_zero),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .beq_redirect(beq_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .fwd_jr(fwd_jr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Instruction-level view of what sits in each later stage.
   typedef struct {
      bit v, rw, is_lw, is_beq;
      int wnum, rs, rt;
   } instr_t;

   typedef struct {
      bit stall, beq, flush_ev;
      bit pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush;
      int fwd_a, fwd_b, fwd_jr;
   } exp_t;

   instr_t m_ex, m_mem, m_wb;
   int     m_stall_cnt, m_flush_cnt;
   bit     last_stall;
   exp_t   exp_now;

   function automatic instr_t idle();
      instr_t n;
      n.v = 0; n.rw = 0; n.is_lw = 0; n.is_beq = 0; n.wnum = 0; n.rs = 0; n.rt = 0;
      return n;
   endfunction

   function automatic instr_t from_id();
      instr_t n;
      n.v = id_valid; n.rw = id_reg_write;
      n.is_lw = (id_inst_type == INST_LW); n.is_beq = (id_inst_type == INST_BEQ);
      n.wnum = int'(id_wnum); n.rs = int'(id_rs); n.rt = int'(id_rt);
      return n;
   endfunction

   function automatic bit writes(instr_t s, int r);
      return s.v && s.rw && s.wnum != 0 && s.wnum == r;
   endfunction

   function automatic int src(instr_t younger_mem, instr_t older_wb, int r);
      if (writes(younger_mem, r)) return 1;
      if (writes(older_wb, r)) return 2;
      return 0;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      bit lu, jw, jf, rf, is_jr;
      is_jr   = (id_inst_type == INST_JR);
      e.beq   = m_mem.v && m_mem.is_beq && mem_zero;
      lu      = m_ex.is_lw && ((id_use_rs && writes(m_ex, int'(id_rs))) ||
                               (id_use_rt && writes(m_ex, int'(id_rt))));
      jw      = is_jr && (writes(m_ex, int'(id_rs)) || (writes(m_mem, int'(id_rs)) && m_mem.is_lw));
      e.stall = id_valid && (lu || jw) && !e.beq;
      jf      = id_valid && (id_inst_type == INST_J_TYPE) && !e.beq;
      rf      = id_valid && is_jr && !e.stall && !e.beq;
      e.flush_ev    = e.beq || jf || rf;
      e.pc_en       = !e.stall;
      e.ifid_en     = !e.stall;
      e.ifid_flush  = e.flush_ev;
      e.idex_flush  = e.stall || e.beq;
      e.exmem_flush = e.beq;
      e.fwd_a  = m_ex.v ? src(m_mem, m_wb, m_ex.rs) : 0;
      e.fwd_b  = m_ex.v ? src(m_mem, m_wb, m_ex.rt) : 0;
      e.fwd_jr = (writes(m_mem, int'(id_rs)) && !m_mem.is_lw) ? 1 :
                 (writes(m_wb, int'(id_rs)) ? 2 : 0);
      return e;
   endfunction

   always_comb exp_now = predict();

   // Advance the model one pipeline step per clock.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ex <= idle(); m_mem <= idle(); m_wb <= idle();
         m_stall_cnt <= 0; m_flush_cnt <= 0; last_stall <= 1'b0;
      end else begin
         m_wb  <= m_mem;
         m_mem <= exp_now.beq ? idle() : m_ex;
         m_ex  <= (exp_now.stall || exp_now.beq) ? idle() : from_id();
         m_stall_cnt <= m_stall_cnt + (exp_now.stall ? 1 : 0);
         m_flush_cnt <= m_flush_cnt + (exp_now.flush_ev ? 1 : 0);
         last_stall  <= exp_now.stall;
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("pc_en",        32'(pc_en),        32'(exp_now.pc_en));
      check("ifid_en",      32'(ifid_en),      32'(exp_now.ifid_en));
      check("ifid_flush",   32'(ifid_flush),   32'(exp_now.ifid_flush));
      check("idex_flush",   32'(idex_flush),   32'(exp_now.idex_flush));
      check("exmem_flush",  32'(exmem_flush),  32'(exp_now.exmem_flush));
      check("beq_redirect", 32'(beq_redirect), 32'(exp_now.beq));
      check("fwd_a",        32'(fwd_a),        32'(exp_now.fwd_a));
      check("fwd_b",        32'(fwd_b),        32'(exp_now.fwd_b));
      check("fwd_jr",       32'(fwd_jr),       32'(exp_now.fwd_jr));
      check("stall_cnt",    stall_cnt,         32'(m_stall_cnt));
      check("flush_cnt",    flush_cnt,         32'(m_flush_cnt));
   end

   task automatic set_id(logic v, logic [2:0] t, logic rw, logic [4:0] w,
                         logic [4:0] rs, logic [4:0] rt, logic urs, logic urt);
      id_valid = v; id_inst_type = t; id_reg_write = rw; id_wnum = w;
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
   endtask

   task automatic nop();
      set_id(1'b0, INST_NORMAL, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_zero = 1'b0; nop();
      #2;
      check("rst pc_en", 32'(pc_en), 32'd1);
      check("rst ifid_en", 32'(ifid_en), 32'd1);
      check("rst flushes", 32'({ifid_flush, idex_flush, exmem_flush, beq_redirect}), 32'd0);
      check("rst fwd", 32'({fwd_a, fwd_b, fwd_jr}), 32'd0);
      check("rst cnt", stall_cnt | flush_cnt, 32'd0);
      cyc(); cyc(); rst = 1'b0;

      // LW $2 ; ADDU $3,$2,$4
      set_id(1'b1, INST_LW, 1'b1, 5'd2, 5'd1, 5'd2, 1'b1, 1'b0); at_neg(); cyc();
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1); at_neg();
      check("lu pc_en", 32'(pc_en), 32'd0);
      check("lu ifid_en", 32'(ifid_en), 32'd0);
      check("lu idex_flush", 32'(idex_flush), 32'd1);
      cyc(); at_neg();
      check("lu released", 32'(pc_en), 32'd1);
      cyc(); nop(); at_neg();
      check("lu fwd_a", 32'(fwd_a), 32'd2);
      check("lu fwd_b", 32'(fwd_b), 32'd0);
      check("lu stall_cnt", stall_cnt, 32'd1);
      cyc();

      // ADDU $5 ; SUBU $6,$5,$5
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd5, 5'd1, 5'd1, 1'b1, 1'b1); at_neg(); cyc();
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1); at_neg();
      check("alu nostall", 32'(pc_en), 32'd1);
      cyc(); nop(); at_neg();
      check("alu fwd_a", 32'(fwd_a), 32'd1);
      check("alu fwd_b", 32'(fwd_b), 32'd1);
      cyc();

      // J, then JAL $31 ; JR $31
      set_id(1'b1, INST_J_TYPE, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); at_neg();
      check("j ifid_flush", 32'(ifid_flush), 32'd1);
      check("j pc_en", 32'(pc_en), 32'd1);
      cyc(); nop(); at_neg();
      check("j one flush", 32'(ifid_flush), 32'd0);
      check("j flush_cnt", flush_cnt, 32'd1);
      cyc();
      set_id(1'b1, INST_J_TYPE, 1'b1, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0); at_neg(); cyc();
      set_id(1'b1, INST_JR, 1'b0, 5'd0, 5'd31, 5'd0, 1'b1, 1'b0); at_neg();
      check("jr stall", 32'(pc_en), 32'd0);
      check("jr no flush", 32'(ifid_flush), 32'd0);
      cyc(); at_neg();
      check("jr go", 32'(pc_en), 32'd1);
      check("jr fwd_jr", 32'(fwd_jr), 32'd1);
      check("jr flush", 32'(ifid_flush), 32'd1);
      cyc(); nop(); at_neg();
      check("jr stall_cnt", stall_cnt, 32'd2);
      check("jr flush_cnt", flush_cnt, 32'd3);
      cyc();

      // BEQ taken, then BEQ not taken
      set_id(1'b1, INST_BEQ, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1); at_neg(); cyc();
      nop(); at_neg(); cyc();
      mem_zero = 1'b1; at_neg();
      check("beq all", 32'({beq_redirect, ifid_flush, idex_flush, exmem_flush, pc_en}), 32'h1f);
      cyc(); mem_zero = 1'b0; at_neg();
      check("beq flush_cnt", flush_cnt, 32'd4);
      cyc();
      set_id(1'b1, INST_BEQ, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1); at_neg(); cyc();
      nop(); at_neg(); cyc(); at_neg();
      check("beq nt", 32'({beq_redirect, ifid_flush, exmem_flush}), 32'd0);
      cyc();

      // BEQ taken against a pending load-use stall
      set_id(1'b1, INST_BEQ, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1); at_neg(); cyc();
      set_id(1'b1, INST_LW, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0); at_neg(); cyc();
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1); mem_zero = 1'b1; at_neg();
      check("prio pc_en", 32'(pc_en), 32'd1);
      check("prio ifid_en", 32'(ifid_en), 32'd1);
      check("prio flush", 32'({beq_redirect, idex_flush, exmem_flush}), 32'h7);
      cyc(); mem_zero = 1'b0; nop(); at_neg();
      check("prio stall_cnt", stall_cnt, 32'd2);
      check("prio flush_cnt", flush_cnt, 32'd5);
      cyc();

      // Writes to $0
      set_id(1'b1, INST_LW, 1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0); at_neg(); cyc();
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1); at_neg();
      check("r0 nostall", 32'(pc_en), 32'd1);
      cyc(); nop(); at_neg();
      check("r0 nofwd", 32'({fwd_a, fwd_b}), 32'd0);
      cyc();

      // Reset in the middle of a load-use stall
      set_id(1'b1, INST_LW, 1'b1, 5'd2, 5'd1, 5'd2, 1'b1, 1'b0); at_neg(); cyc();
      set_id(1'b1, INST_NORMAL, 1'b1, 5'd3, 5'd2, 5'd2, 1'b1, 1'b1); #2;
      check("mid stall", 32'(pc_en), 32'd0);
      rst = 1'b1; #1;
      check("async pc_en", 32'({pc_en, ifid_en}), 32'h3);
      check("async idex", 32'(idex_flush), 32'd0);
      check("async cnt", stall_cnt | flush_cnt, 32'd0);
      cyc(); cyc(); rst = 1'b0; nop();

      // Random control bundles; the ID bundle is held while the model says stall.
      for (int i = 0; i < 4000; i++) begin
         cyc();
         mem_zero = 1'($urandom_range(0, 1));
         if (!last_stall) begin
            set_id(1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      cyc(); nop(); mem_zero = 1'b0; at_neg(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock unit for the 5-stage MIPS core. It consumes the decoded control bundle that ctrl emits in ID (reg_write, inst_type, destination register) and turns it into stall, flush and forwarding controls.
- It keeps its own shadow scoreboard of the EX, MEM and WB stages, so the datapath does not have to feed tags back.
- J/JAL resolve in ID, JR resolves in ID with MEM->ID forwarding, and BEQ resolves in MEM with predict-not-taken.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_inst_type  in  3  ctrl inst_type (`INST_NORMAL/`INST_JR/`INST_LW/`INST_J_TYPE/`INST_BEQ from def.v).
- id_reg_write  in  1  ctrl reg_write.
- id_wnum  in  REG_W  resolved destination register (rd/rt/31).
- id_rs, id_rt  in  REG_W  source registers.
- id_use_rs, id_use_rt  in  1  the instruction reads rs / rt.
- mem_zero  in  1  ALU zero of the instruction currently in MEM.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  zero IF/ID.
- idex_flush  out  1  insert a bubble into ID/EX.
- exmem_flush  out  1  insert a bubble into EX/MEM.
- beq_redirect  out  1  select the BEQ target from MEM.
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fwd_jr  out  2  JR target source in ID: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Scoreboard:
  - Entries EX, MEM, WB, each holding {v, rw, wnum, is_lw, is_beq, rs, rt, use_rs, use_rt}.
  - Each cycle: WB<=MEM, MEM<=EX, EX<=ID fields (v=id_valid).
  - On stall, EX<=bubble (v=0) while MEM/WB still advance.
  - On BEQ-taken flush, EX<=bubble and MEM<=bubble.
- Reset (asynchronous): all entries have v=0, counters are 0.
  - Combinational outputs then evaluate to pc_en=1, ifid_en=1, all flush/redirect=0, fwd_*=00.
- Hazard match: a producer matches when v && rw && wnum!=0 && wnum==reg. Register 0 never matches.
- load_use: EX.is_lw matches (id_use_rs ? id_rs) or (id_use_rt ? id_rt).
- jr_wait: ID is JR and rs matches EX (any producer), or matches MEM with MEM.is_lw.
- stall = id_valid && (load_use || jr_wait) && !beq_take.
  - Effect: pc_en=0, ifid_en=0, idex_flush=1.
  - Duration: exactly 1 cycle for a load-use; 1 or 2 cycles for JR depending on producer distance.
- beq_take = MEM.v && MEM.is_beq && mem_zero.
  - Effect: beq_redirect=1, ifid_flush=1, idex_flush=1, exmem_flush=1, pc_en=1.
  - It squashes the three younger instructions.
  - It has priority over stall and over the J flush (those instructions are wrong-path).
- J/JAL in ID (id_valid, `INST_J_TYPE) with no beq_take: ifid_flush=1 for one cycle, no stall.
- JR in ID with no stall and no beq_take: ifid_flush=1.
- Forwarding to EX:
  - fwd_a=01 if MEM matches EX.rs; else 10 if WB matches EX.rs; else 00. MEM has priority.
  - fwd_b is the same rule on EX.rt.
  - Not applied when EX.v=0.
- fwd_jr: 01 if MEM matches id_rs and !MEM.is_lw; else 10 if WB matches; else 00.
- Counters:
  - stall_cnt increments on each stall cycle.
  - flush_cnt increments on each beq_take, J flush and JR flush.
  - Both wrap modulo 2^CNT_W.
- Back-to-back BEQ: only the oldest (in MEM) acts; the younger ones are already squashed.
- Reset mid-stall discards all state immediately.

Decomposition:
- Shared constants live in def.v: the `INST_* encodings plus new `FWD_REG=2'b00, `FWD_MEM=2'b01, `FWD_WB=2'b10.
- One sub-module, hazard_sb_stage: a single scoreboard entry register with async reset, advance and bubble inputs. It is instantiated three times.

Test Plan:
- LW $2 then ADDU $3,$2,$4 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_a=10; stall_cnt=1.
- ADDU $5,... then SUBU $6,$5,$5 -> no stall; fwd_a=01 and fwd_b=01 in the consumer's EX cycle.
- J target -> exactly one ifid_flush cycle, no stall, flush_cnt=1; a JAL writing $31 then JR $31 one slot later -> 1 stall cycle, then fwd_jr=01.
- BEQ with mem_zero=1 -> in its MEM cycle beq_redirect=1 and ifid/idex/exmem_flush=1 together; mem_zero=0 -> no flush.
- BEQ taken while an LW load-use stall is pending in ID -> flush wins, stall=0, pc_en=1, stall_cnt unchanged.
- Assert rst mid-stall -> outputs return to reset values in the same cycle without a clock edge; writes to $0 never trigger forwarding or stall.
